// File: rtl/serial_parity_pkg.sv
// Shared types and defaults for the serial parity receiver.
// The state encoding is fixed so that waveform dumps stay comparable with older captures.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } rx_state_e;

    localparam int unsigned DEFAULT_DATA_W   = 8;
    localparam int unsigned DEFAULT_ERRCNT_W = 8;

endpackage

// File: rtl/parity_accum.sv
// Running XOR of accepted serial bits.
// A clear takes priority over an enabled bit in the same cycle.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic acc
);

    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = 1'b0;
        end else if (en) begin
            acc_d = acc_q ^ bit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: DATA_W data bits LSB first followed by one parity bit.
// Reports the assembled word, a parity-error flag and a saturating bad-frame count.
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter bit          ODD_PARITY = 1'b1,
    parameter int unsigned ERRCNT_W   = DEFAULT_ERRCNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                bit_in,
    input  logic                bit_vld,
    input  logic                abort,
    output logic                busy,
    output logic [DATA_W-1:0]   data_out,
    output logic                parity_err,
    output logic                frame_vld,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     shift_q, shift_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  fvld_q, fvld_d;
    logic                  busy_q, busy_d;
    logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;

    logic acc_clr;
    logic acc_en;
    logic acc;

    parity_accum u_parity_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (bit_in),
        .acc    (acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        perr_d   = perr_q;
        fvld_d   = 1'b0;
        errcnt_d = errcnt_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;

        case (state_q)
            IDLE: begin
                // start beats abort here; bit_vld is ignored until DATA
                if (start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    acc_clr = 1'b1;
                end
            end
            DATA: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_vld) begin
                    shift_d[cnt_q] = bit_in;
                    acc_en         = 1'b1;
                    cnt_d          = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = PAR;
                    end
                end
            end
            PAR: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_vld) begin
                    perr_d  = (bit_in != (acc ^ ODD_PARITY));
                    data_d  = shift_q;
                    fvld_d  = 1'b1;
                    state_d = IDLE;
                    if (perr_d && (errcnt_q != '1)) begin
                        errcnt_d = errcnt_q + ERRCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Decoding the next state keeps busy aligned with the registered state.
        busy_d = (state_d == DATA) || (state_d == PAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            fvld_q   <= 1'b0;
            busy_q   <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            perr_q   <= perr_d;
            fvld_q   <= fvld_d;
            busy_q   <= busy_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign busy       = busy_q;
    assign data_out   = data_q;
    assign parity_err = perr_q;
    assign frame_vld  = fvld_q;
    assign err_cnt    = errcnt_q;

endmodule
